// File: rtl/spi_master_mc_pkg.sv
// Shared types and constants for the multi-channel SPI master.
package spi_master_mc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int unsigned EDGES_PER_BYTE = 16;
  localparam int unsigned EDGEW          = 5;
  localparam int unsigned CPOL_B         = 1;
  localparam int unsigned CPHA_B         = 0;

  // Shift a byte left by one, back-filling with 1 so MOSI idles high.
  function automatic logic [7:0] shl1(input logic [7:0] v);
    return {v[6:0], 1'b1};
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider: toggles SCLK every div+1 clocks while running and reports each edge.
module spi_sclk_gen
  import spi_master_mc_pkg::*;
#(
  parameter int unsigned DIVW = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,
  input  logic [DIVW-1:0]  div_i,
  input  logic             cpol_i,
  output logic             sclk_o,
  output logic             edge_c_o,
  output logic [EDGEW-1:0] edge_idx_o
);

  logic [DIVW-1:0]  cnt_q;
  logic [EDGEW-1:0] idx_q;
  logic             sclk_q;

  assign edge_c_o   = run_i && (cnt_q == div_i);
  assign sclk_o     = sclk_q;
  assign edge_idx_o = idx_q;

  // Half-period counter, edge index and SCLK level; SCLK parks at CPOL when idle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      sclk_q <= 1'b0;
    end else if (!run_i) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      sclk_q <= cpol_i;
    end else if (edge_c_o) begin
      cnt_q  <= '0;
      idx_q  <= idx_q + EDGEW'(1);
      sclk_q <= ~sclk_q;
    end else begin
      cnt_q  <= cnt_q + DIVW'(1);
    end
  end

endmodule

// File: rtl/spi_master_mc.sv
// Byte-wide SPI master shared by NCS chip-select channels with runtime divider and mode.
module spi_master_mc
  import spi_master_mc_pkg::*;
#(
  parameter int unsigned     NCS     = 2,
  parameter int unsigned     DIVW    = 8,
  parameter logic [DIVW-1:0] DIV_RST = '0,
  parameter logic [7:0]      IDLE_TX = 8'hFF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cs_wr,
  input  logic [NCS-1:0]  cs_din,
  input  logic            cfg_wr,
  input  logic [DIVW-1:0] cfg_div,
  input  logic [1:0]      cfg_mode,
  input  logic            tx_wr,
  input  logic            rx_rd,
  input  logic [7:0]      din,
  output logic [7:0]      dout,
  output logic            oe_n,
  output logic            wait_n,
  output logic [NCS-1:0]  spi_cs_n,
  output logic            spi_clk,
  output logic            spi_mosi,
  input  logic [NCS-1:0]  spi_miso
);

  state_e           state_q;
  logic [NCS-1:0]   cs_q, cs_d, cs_pend_val_q;
  logic             cs_pend_q, cfg_pend_q;
  logic [DIVW-1:0]  div_q, div_d, cfg_pend_div_q;
  logic [1:0]       mode_q, mode_d, cfg_pend_mode_q;
  logic             cs_wr_q, cfg_wr_q, tx_wr_q, rx_rd_q;
  logic [7:0]       tx_sr_q, rx_sr_q, dout_q;
  logic             mosi_q, wait_n_q;
  logic             cs_e, cfg_e, tx_e, rx_e, start_e;
  logic [7:0]       start_byte;
  logic             sclk, edge_c, miso_c, found, cpha, sample_c, shift_c, last_c;
  logic [EDGEW-1:0] edge_idx;

  assign cs_e       = cs_wr & ~cs_wr_q;
  assign cfg_e      = cfg_wr & ~cfg_wr_q;
  assign tx_e       = tx_wr & ~tx_wr_q;
  assign rx_e       = rx_rd & ~rx_rd_q;
  assign start_e    = tx_e | rx_e;
  assign start_byte = tx_e ? din : IDLE_TX;

  assign cpha     = mode_q[CPHA_B];
  assign sample_c = edge_c & (cpha ? edge_idx[0] : ~edge_idx[0]);
  assign shift_c  = edge_c & (cpha ? ~edge_idx[0] : edge_idx[0]);
  assign last_c   = edge_c & (edge_idx == EDGEW'(EDGES_PER_BYTE - 1));

  assign dout     = dout_q;
  assign oe_n     = ~rx_rd;
  assign wait_n   = wait_n_q;
  assign spi_cs_n = cs_q;
  assign spi_clk  = sclk;
  assign spi_mosi = mosi_q;

  // MISO from the lowest-index selected channel, 1 when nothing is selected.
  always_comb begin
    miso_c = 1'b1;
    found  = 1'b0;
    for (int i = 0; i < NCS; i++) begin
      if (!found && !cs_q[i]) begin
        miso_c = spi_miso[i];
        found  = 1'b1;
      end
    end
  end

  // CS/divider/mode update: immediate in IDLE, deferred to DONE while a byte is in flight.
  always_comb begin
    cs_d   = cs_q;
    div_d  = div_q;
    mode_d = mode_q;
    if (state_q == ST_IDLE) begin
      if (cs_e) cs_d = cs_din;
      if (cfg_e) begin
        div_d  = cfg_div;
        mode_d = cfg_mode;
      end
    end else if (state_q == ST_DONE) begin
      if (cs_e)           cs_d = cs_din;
      else if (cs_pend_q) cs_d = cs_pend_val_q;
      if (cfg_e) begin
        div_d  = cfg_div;
        mode_d = cfg_mode;
      end else if (cfg_pend_q) begin
        div_d  = cfg_pend_div_q;
        mode_d = cfg_pend_mode_q;
      end
    end
  end

  spi_sclk_gen #(.DIVW(DIVW)) u_sclk (
    .clk_i      (clk),
    .rst_i      (rst),
    .run_i      (state_q == ST_SHIFT),
    .div_i      (div_q),
    .cpol_i     (mode_d[CPOL_B]),
    .sclk_o     (sclk),
    .edge_c_o   (edge_c),
    .edge_idx_o (edge_idx)
  );

  // Transfer FSM, shift registers, strobe history and pending updates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      cs_q            <= '1;
      div_q           <= DIV_RST;
      mode_q          <= 2'b00;
      cs_pend_q       <= 1'b0;
      cs_pend_val_q   <= '1;
      cfg_pend_q      <= 1'b0;
      cfg_pend_div_q  <= DIV_RST;
      cfg_pend_mode_q <= 2'b00;
      cs_wr_q         <= 1'b0;
      cfg_wr_q        <= 1'b0;
      tx_wr_q         <= 1'b0;
      rx_rd_q         <= 1'b0;
      tx_sr_q         <= 8'hFF;
      rx_sr_q         <= 8'hFF;
      dout_q          <= 8'hFF;
      mosi_q          <= 1'b1;
      wait_n_q        <= 1'b1;
    end else begin
      cs_wr_q  <= cs_wr;
      cfg_wr_q <= cfg_wr;
      tx_wr_q  <= tx_wr;
      rx_rd_q  <= rx_rd;
      cs_q     <= cs_d;
      div_q    <= div_d;
      mode_q   <= mode_d;

      if (state_q == ST_SHIFT) begin
        if (cs_e) begin
          cs_pend_q     <= 1'b1;
          cs_pend_val_q <= cs_din;
        end
        if (cfg_e) begin
          cfg_pend_q      <= 1'b1;
          cfg_pend_div_q  <= cfg_div;
          cfg_pend_mode_q <= cfg_mode;
        end
      end else begin
        cs_pend_q  <= 1'b0;
        cfg_pend_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (start_e) begin
            state_q  <= ST_SHIFT;
            wait_n_q <= 1'b0;
            if (mode_d[CPHA_B]) begin
              tx_sr_q <= start_byte;
            end else begin
              mosi_q  <= start_byte[7];
              tx_sr_q <= shl1(start_byte);
            end
          end
        end
        ST_SHIFT: begin
          if (shift_c) begin
            mosi_q  <= tx_sr_q[7];
            tx_sr_q <= shl1(tx_sr_q);
          end
          if (sample_c) rx_sr_q <= {rx_sr_q[6:0], miso_c};
          if (last_c)   state_q <= ST_DONE;
        end
        ST_DONE: begin
          state_q  <= ST_IDLE;
          wait_n_q <= 1'b1;
          dout_q   <= rx_sr_q;
          mosi_q   <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_mc.sv
// Self-checking bench for spi_master_mc with a behavioural SPI slave.
module tb_spi_master_mc;

  localparam int unsigned NCS  = 2;
  localparam int unsigned DIVW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            cs_wr, cfg_wr, tx_wr, rx_rd;
  logic [NCS-1:0]  cs_din;
  logic [DIVW-1:0] cfg_div;
  logic [1:0]      cfg_mode;
  logic [7:0]      din, dout;
  logic            oe_n, wait_n, spi_clk, spi_mosi;
  logic [NCS-1:0]  spi_cs_n, spi_miso;

  spi_master_mc #(.NCS(NCS), .DIVW(DIVW)) dut (
    .clk(clk), .rst(rst), .cs_wr(cs_wr), .cs_din(cs_din), .cfg_wr(cfg_wr),
    .cfg_div(cfg_div), .cfg_mode(cfg_mode), .tx_wr(tx_wr), .rx_rd(rx_rd),
    .din(din), .dout(dout), .oe_n(oe_n), .wait_n(wait_n), .spi_cs_n(spi_cs_n),
    .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  logic [1:0] tb_mode;
  logic [7:0] slv [NCS];
  int         edge_cnt = 0;
  logic [7:0] mosi_cap;
  int         half_bad;
  time        last_t, exp_half;
  logic [7:0] model_dout;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Slave view: count SCLK edges of the current byte, capture MOSI on its sampling edges.
  always @(negedge wait_n) begin
    edge_cnt = 0;
    mosi_cap = 8'h00;
  end

  always @(spi_clk) begin
    if (rst === 1'b0 && wait_n === 1'b0) begin
      edge_cnt++;
      if (edge_cnt > 1 && ($time - last_t) != exp_half) half_bad++;
      last_t = $time;
      if (((edge_cnt % 2) == 1) == (tb_mode[0] == 1'b0))
        mosi_cap = {mosi_cap[6:0], spi_mosi};
    end
  end

  // Bit the slave drives after e SCLK edges: CPHA=0 changes on even edges, CPHA=1 on odd ones.
  function automatic logic slave_bit(input logic [7:0] b, input int e, input logic cpha);
    int n;
    if (cpha && e == 0) return 1'b1;
    n = cpha ? (e - 1) / 2 : e / 2;
    if (n < 0 || n > 7) return 1'b1;
    return b[7-n];
  endfunction

  always_comb begin
    spi_miso = '1;
    for (int i = 0; i < NCS; i++) spi_miso[i] = slave_bit(slv[i], edge_cnt, tb_mode[0]);
  end

  task automatic setup(input logic [1:0] cs, input logic [7:0] div, input logic [1:0] mode,
                       input logic [7:0] s0, input logic [7:0] s1);
    @(posedge clk); #1;
    cs_din = cs; cs_wr = 1'b1; cfg_div = div; cfg_mode = mode; cfg_wr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cs_wr = 1'b0; cfg_wr = 1'b0;
    tb_mode = mode; slv[0] = s0; slv[1] = s1;
    exp_half = 64'(div) * 10 + 10;
    @(posedge clk); #1;
    chk("cfg_cs", 32'(spi_cs_n), 32'(cs));
    chk("cpol_idle", 32'(spi_clk), 32'(mode[1]));
  endtask

  // One byte transfer; mid=1 also pokes cs_wr and a second tx_wr while shifting.
  task automatic run_xfer(input logic do_wr, input logic do_rd, input logic [7:0] data, input int mid,
                          input logic [7:0] exp_mosi, input logic [7:0] exp_rx, input int exp_low,
                          input string tag);
    int   low = 0;
    int   it = 0;
    int   rd_bad = 0;
    int   cs_bad = 0;
    int   extra = 0;
    logic first_w = 1'b1;
    half_bad = 0;
    @(posedge clk); #1;
    din = data; tx_wr = do_wr; rx_rd = do_rd;
    while (it < 2000) begin
      @(posedge clk); #1;
      it++;
      if (it == 1) first_w = wait_n;
      if (wait_n === 1'b0) low++;
      if (rx_rd && (dout !== model_dout || oe_n !== 1'b0)) rd_bad++;
      if (mid == 1 && wait_n === 1'b0 && spi_cs_n !== 2'b10) cs_bad++;
      if (it == 3) begin tx_wr = 1'b0; rx_rd = 1'b0; end
      if (mid == 1 && it == 5) begin cs_din = 2'b11; cs_wr = 1'b1; din = 8'hFF; tx_wr = 1'b1; end
      if (mid == 1 && it == 8) begin cs_wr = 1'b0; tx_wr = 1'b0; end
      if (it > 1 && wait_n === 1'b1) break;
    end
    chk({tag, "_busy_start"}, 32'(first_w), 32'(0));
    chk({tag, "_busy_len"}, 32'(low), 32'(exp_low));
    chk({tag, "_mosi"}, 32'(mosi_cap), 32'(exp_mosi));
    chk({tag, "_dout"}, 32'(dout), 32'(exp_rx));
    chk({tag, "_half"}, 32'(half_bad), 32'(0));
    chk({tag, "_sclk_idle"}, 32'(spi_clk), 32'(tb_mode[1]));
    chk({tag, "_read_hold"}, 32'(rd_bad), 32'(0));
    chk({tag, "_oe_n_idle"}, 32'(oe_n), 32'(1));
    if (mid == 1) begin
      chk({tag, "_cs_hold"}, 32'(cs_bad), 32'(0));
      chk({tag, "_cs_after"}, 32'(spi_cs_n), 32'(2'b11));
    end
    repeat (5) begin
      @(posedge clk); #1;
      if (wait_n !== 1'b1) extra++;
    end
    chk({tag, "_no_extra"}, 32'(extra), 32'(0));
    model_dout = exp_rx;
  endtask

  typedef struct {
    logic       rd;
    logic [7:0] data;
    logic [1:0] cs;
    logic [7:0] div;
    logic [1:0] mode;
    logic [7:0] s0, s1;
    logic [7:0] exp_mosi, exp_rx;
    int         exp_low;
  } vec_t;

  vec_t vt [6];

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d, s0, s1, rx, div;
    logic [1:0] cs, mode;
    logic       rd;
    int         n;

    vt[0] = '{1'b0, 8'hA5, 2'b10, 8'd0, 2'd0, 8'h3C, 8'h81, 8'hA5, 8'h3C, 17};
    vt[1] = '{1'b1, 8'h00, 2'b01, 8'd0, 2'd0, 8'h3C, 8'h81, 8'hFF, 8'h81, 17};
    vt[2] = '{1'b0, 8'h00, 2'b10, 8'd3, 2'd3, 8'hC3, 8'h11, 8'h00, 8'hC3, 65};
    vt[3] = '{1'b0, 8'h5A, 2'b10, 8'd1, 2'd1, 8'h96, 8'h22, 8'h5A, 8'h96, 33};
    vt[4] = '{1'b0, 8'h0F, 2'b00, 8'd2, 2'd2, 8'hE7, 8'h18, 8'h0F, 8'hE7, 49};
    vt[5] = '{1'b0, 8'h12, 2'b11, 8'd0, 2'd0, 8'h44, 8'h55, 8'h12, 8'hFF, 17};

    rst = 1'b1; cs_wr = 0; cfg_wr = 0; tx_wr = 0; rx_rd = 0;
    cs_din = '1; cfg_div = '0; cfg_mode = '0; din = '0;
    tb_mode = 2'b00; slv[0] = 8'hFF; slv[1] = 8'hFF; exp_half = 10; model_dout = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cs_n", 32'(spi_cs_n), 32'(2'b11));
    chk("rst_sclk", 32'(spi_clk), 32'(0));
    chk("rst_mosi", 32'(spi_mosi), 32'(1));
    chk("rst_dout", 32'(dout), 32'(8'hFF));
    chk("rst_wait_n", 32'(wait_n), 32'(1));
    chk("rst_oe_n", 32'(oe_n), 32'(1));
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      setup(vt[i].cs, vt[i].div, vt[i].mode, vt[i].s0, vt[i].s1);
      run_xfer(!vt[i].rd, vt[i].rd, vt[i].data, 0, vt[i].exp_mosi, vt[i].exp_rx, vt[i].exp_low,
               $sformatf("vec%0d", i));
    end

    // CS and second write arriving mid-byte
    setup(2'b10, 8'd0, 2'd0, 8'h5A, 8'h00);
    run_xfer(1'b1, 1'b0, 8'h3C, 1, 8'h3C, 8'h5A, 17, "midcs");

    // tx_wr and rx_rd rising together
    setup(2'b10, 8'd0, 2'd0, 8'h99, 8'h00);
    run_xfer(1'b1, 1'b1, 8'h55, 0, 8'h55, 8'h99, 17, "both");

    // Reset at the 7th SCLK edge
    setup(2'b10, 8'd1, 2'd0, 8'hC3, 8'h00);
    edge_cnt = 0;
    @(posedge clk); #1;
    din = 8'hC3; tx_wr = 1'b1;
    n = 0;
    while (edge_cnt < 7 && n < 500) begin
      @(posedge clk); #1;
      n++;
      if (n == 3) tx_wr = 1'b0;
    end
    tx_wr = 1'b0;
    chk("rst_mid_reached", 32'(edge_cnt), 32'(7));
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_cs_n", 32'(spi_cs_n), 32'(2'b11));
    chk("rst_mid_sclk", 32'(spi_clk), 32'(0));
    chk("rst_mid_wait_n", 32'(wait_n), 32'(1));
    chk("rst_mid_dout", 32'(dout), 32'(8'hFF));
    @(posedge clk); #1;
    rst = 1'b0;
    model_dout = 8'hFF;
    tb_mode = 2'b00;
    setup(2'b10, 8'd0, 2'd0, 8'h6E, 8'h00);
    run_xfer(1'b1, 1'b0, 8'hB1, 0, 8'hB1, 8'h6E, 17, "post_rst");

    // Randomised transfers against the slave/selection model
    for (int r = 0; r < 10; r++) begin
      rd   = 1'($urandom % 2);
      d    = 8'($urandom);
      cs   = 2'($urandom % 4);
      div  = 8'($urandom % 4);
      mode = 2'($urandom % 4);
      s0   = 8'($urandom);
      s1   = 8'($urandom);
      rx   = !cs[0] ? s0 : (!cs[1] ? s1 : 8'hFF);
      setup(cs, div, mode, s0, s1);
      run_xfer(!rd, rd, d, 0, rd ? 8'hFF : d, rx, 16 * (int'(div) + 1) + 1, $sformatf("rnd%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_master_mc.md
Name: spi_master_mc

Overview:
- Parametrised successor to the boot-flash/SD SPI front end.
- A single byte-wide SPI master shared by NCS chip-select channels (flash, SD, future ones), with a runtime SCLK divider and runtime SPI mode (CPOL/CPHA).
- Sits behind the ZXUNO register/port decoder. Byte transfers start on CPU write or read strobes, and wait_n stalls the CPU while a byte is shifting.

Parameters:
- NCS, 2, number of chip-select channels (1..8).
- DIVW, 8, width of the SCLK divider register.
- DIV_RST, 0, reset value of the divider (half-period = DIV+1 clk cycles).
- IDLE_TX, 8'hFF, byte shifted out when a transfer is started by a read.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cs_wr  in  1  level strobe: load CS register
- cs_din  in  NCS  new CS pattern, active-low per channel
- cfg_wr  in  1  level strobe: load divider and mode
- cfg_div  in  DIVW  SCLK half-period minus 1
- cfg_mode  in  2  {CPOL,CPHA}
- tx_wr  in  1  level strobe: send din
- rx_rd  in  1  level strobe: read last byte, start IDLE_TX transfer
- din  in  8  CPU write data
- dout  out  8  last received byte
- oe_n  out  1  low while rx_rd is high (dout valid)
- wait_n  out  1  low while transfer in progress
- spi_cs_n  out  NCS  chip selects
- spi_clk  out  1  SCLK
- spi_mosi  out  1  MOSI
- spi_miso  in  NCS  per-channel MISO

Behaviour:
Reset values (async, immediate):
- spi_cs_n all 1; spi_clk = CPOL (reset CPOL=0, so 0); spi_mosi 1; dout 8'hFF; wait_n 1; divider DIV_RST; mode 0; FSM IDLE.

Strobe edge detection:
- All strobes are level inputs from CPU decode and are held for several clk cycles.
- Each strobe acts once, on its 0->1 transition, via a registered previous-value compare.
- oe_n is combinational: ~rx_rd.

Start of transfer:
- Only in IDLE. The shift register loads din (tx_wr) or IDLE_TX (rx_rd).
- tx_wr and rx_rd rising in the same cycle: tx_wr wins.
- On rx_rd, dout presents the byte from the previous transfer for the whole read. dout updates only at the end of the next transfer.

Busy handling:
- wait_n goes low the cycle after the start edge and returns high the cycle after the last SCLK edge.
- Start edges arriving while not IDLE are ignored. No queuing.

FSM states:
- IDLE -> SHIFT on start.
- SHIFT: 16 SCLK half-periods, each DIV+1 clk cycles long.
- SHIFT -> DONE after the 16th half-period.
- DONE -> IDLE after 1 cycle: dout <= rx shift register, wait_n high.

Transfer latency:
- 16*(DIV+1)+2 clk cycles from start edge to wait_n high.
- DIV=0 gives 18 cycles; max DIV gives 16*2^DIVW+2.

Bit order and mode:
- MSB first.
- CPHA=0: MOSI valid from SHIFT entry; sample on the 1st, 3rd, ... edge; shift on the 2nd, 4th, ... edge.
- CPHA=1: shift on odd edges, sample on even edges.
- SCLK idles at CPOL in IDLE/DONE.

MISO selection:
- Taken from the lowest-index channel whose spi_cs_n is 0.
- If no channel is selected, MISO reads as 1.

CS register:
- cs_wr edge loads cs_din directly. Multiple active channels are permitted; software is responsible.
- A cs_wr edge during SHIFT is held pending and applied on the DONE->IDLE transition, so CS never glitches mid-byte.

Configuration:
- A cfg_wr edge applies in IDLE only.
- During SHIFT it is held pending and applied at DONE, like CS.
- A CPOL change applies to spi_clk on the cycle it is applied.

Counter width:
- The divider counter is DIVW bits and wraps at cfg_div.
- The edge counter is 5 bits (0..16).

Reset mid-transfer:
- Everything returns to reset values asynchronously.
- CS deasserts immediately; the partial byte is discarded.

Decomposition:
- Package spi_master_mc_pkg:
  - FSM state encoding (IDLE/SHIFT/DONE)
  - EDGES_PER_BYTE = 16
  - mode bit indices CPOL_B = 1, CPHA_B = 0
- Sub-module spi_sclk_gen:
  - divider counter plus SCLK toggle
  - emits a one-cycle "edge" pulse and edge index
  - inputs: clk, rst, run, div, cpol

Test Plan:
- Reset, then DIV=0, mode 0, cs_din=2'b10, tx_wr 8'hA5 with a loopback slave on channel 0 returning 8'h3C -> MOSI shows 1010_0101 MSB first; wait_n low for exactly 17 cycles; then rx_rd gives dout=8'h3C, oe_n low only during rx_rd.
- rx_rd with channel 1 selected, slave returns 8'h81 -> MOSI shifts 8'hFF; dout stays at the previous value during that read; the next read returns 8'h81.
- cfg_div=3, mode 3 (CPOL=1, CPHA=1), tx_wr 8'h00 -> SCLK idles high; half-period 4 cycles; transfer 66 cycles start-edge to wait_n high; sampling on rising SCLK edges.
- During SHIFT, pulse cs_wr with 2'b11 and a second tx_wr 8'hFF -> CS stays 2'b10 until DONE, then 2'b11; second write ignored; MOSI byte unchanged.
- tx_wr and rx_rd rising on the same cycle with din=8'h55 -> exactly one transfer, MOSI=8'h55.
- rst asserted at edge 7 of a transfer -> spi_cs_n=all 1, spi_clk=0, wait_n=1, dout=8'hFF immediately; a following transfer completes normally.
